axi4_write_master: RTL

AXI4 write-side initiator that turns one local write command plus a stream of data beats into a complete AXI4 write transaction on the AW, W and B channels, then reports the write response. It is the master-side counterpart of the AXI4 slave in the same design, and connects directly to that slave's write ports for the subsystem loopback bench. It supports one outstanding transaction, FIXED/INCR/WRAP bursts, 1–256 beats and 1/2/4-byte beats.

---
 rtl/axi4_write_master.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/axi4_write_master.sv
// AXI4 write-side initiator: one command plus a stream of data beats becomes one AW/W/B
// transaction, with a registered completion pulse carrying the response and ID check.
`timescale 1ns/1ps
module axi4_write_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic                ACLK,
   input  logic                ARESETn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [ID_W-1:0]     cmd_id,
   input  logic [7:0]          cmd_len,
   input  logic [2:0]          cmd_size,
   input  logic [1:0]          cmd_burst,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_strb,
   output logic                done_valid,
   output logic [1:0]          done_resp,
   output logic [ID_W-1:0]     done_id,
   output logic                done_id_err,
   output logic                busy,
   output logic                AWVALID,
   input  logic                AWREADY,
   output logic [ID_W-1:0]     AWID,
   output logic [ADDR_W-1:0]   AWADDR,
   output logic [7:0]          AWLEN,
   output logic [2:0]          AWSIZE,
   output logic [1:0]          AWBURST,
   output logic                WVALID,
   input  logic                WREADY,
   output logic [ID_W-1:0]     WID,
   output logic [DATA_W-1:0]   WDATA,
   output logic [DATA_W/8-1:0] WSTRB,
   output logic                WLAST,
   input  logic                BVALID,
   output logic                BREADY,
   input  logic [ID_W-1:0]     BID,
   input  logic [1:0]          BRESP
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, ERR} state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [ADDR_W-1:0]     r_addr;
   logic [ID_W-1:0]       r_id;
   logic [7:0]            r_len;
   logic [2:0]            r_size;
   logic [1:0]            r_burst;
   logic [7:0]            r_beatCnt;
   logic                  r_allBeats;
   logic                  r_wvalid;
   logic                  r_wlast;
   logic [DATA_W-1:0]     r_wdata;
   logic [DATA_W/8-1:0]   r_wstrb;
   logic                  r_doneValid;
   logic [1:0]            r_doneResp;
   logic [ID_W-1:0]       r_doneId;
   logic                  r_doneIdErr;
   logic                  w_cmdFire;
   logic                  w_cmdIllegal;
   logic                  w_beatFire;
   logic                  w_wFire;
   logic                  w_bFire;

   assign cmd_ready    = ARESETn && (r_state == IDLE);
   assign w_cmdFire    = cmd_valid && cmd_ready;
   assign w_cmdIllegal = (cmd_size > 3'd2) || (cmd_burst == 2'b11) ||
                         ((cmd_burst == 2'b10) && (cmd_len != 8'd1) && (cmd_len != 8'd3) &&
                          (cmd_len != 8'd7) && (cmd_len != 8'd15));
   // The W register refills in the same cycle it drains, so a steady WREADY gives one beat per clock.
   assign wr_ready     = ARESETn && (r_state == DATA) && !r_allBeats && (!r_wvalid || WREADY);
   assign w_beatFire   = wr_valid && wr_ready;
   assign w_wFire      = r_wvalid && WREADY;
   assign w_bFire      = (r_state == RESP) && BVALID;

   assign busy        = (r_state != IDLE);
   assign AWVALID     = (r_state == ADDR);
   assign AWID        = r_id;
   assign AWADDR      = r_addr;
   assign AWLEN       = r_len;
   assign AWSIZE      = r_size;
   assign AWBURST     = r_burst;
   assign WVALID      = r_wvalid;
   assign WID         = r_id;
   assign WDATA       = r_wdata;
   assign WSTRB       = r_wstrb;
   assign WLAST       = r_wlast;
   assign BREADY      = (r_state == RESP);
   assign done_valid  = r_doneValid;
   assign done_resp   = r_doneResp;
   assign done_id     = r_doneId;
   assign done_id_err = r_doneIdErr;

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_cmdFire) w_nextState = w_cmdIllegal ? ERR : ADDR;
         ADDR:    if (AWREADY) w_nextState = DATA;
         DATA:    if (w_wFire && r_wlast) w_nextState = RESP;
         RESP:    if (BVALID) w_nextState = IDLE;
         ERR:     w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) r_state <= IDLE;
      else          r_state <= w_nextState;
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         r_addr      <= '0;
         r_id        <= '0;
         r_len       <= '0;
         r_size      <= '0;
         r_burst     <= '0;
         r_beatCnt   <= '0;
         r_allBeats  <= 1'b0;
         r_wvalid    <= 1'b0;
         r_wlast     <= 1'b0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_doneValid <= 1'b0;
         r_doneResp  <= '0;
         r_doneId    <= '0;
         r_doneIdErr <= 1'b0;
      end else begin
         r_doneValid <= 1'b0;
         if (w_cmdFire) begin
            r_addr     <= cmd_addr;
            r_id       <= cmd_id;
            r_len      <= cmd_len;
            r_size     <= cmd_size;
            r_burst    <= cmd_burst;
            r_beatCnt  <= '0;
            r_allBeats <= 1'b0;
         end
         // The counter parks at len after the last beat so a 256-beat burst never wraps.
         if (w_beatFire) begin
            r_wvalid <= 1'b1;
            r_wdata  <= wr_data;
            r_wstrb  <= wr_strb;
            r_wlast  <= (r_beatCnt == r_len);
            if (r_beatCnt == r_len) r_allBeats <= 1'b1;
            else                    r_beatCnt  <= r_beatCnt + 8'd1;
         end else if (w_wFire) begin
            r_wvalid <= 1'b0;
            r_wlast  <= 1'b0;
         end
         if (w_bFire) begin
            r_doneValid <= 1'b1;
            r_doneResp  <= BRESP;
            r_doneId    <= r_id;
            r_doneIdErr <= (BID != r_id);
         end else if (r_state == ERR) begin
            r_doneValid <= 1'b1;
            r_doneResp  <= 2'b10;
            r_doneId    <= r_id;
            r_doneIdErr <= 1'b0;
         end
      end
   end

endmodule
